// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ser_pkg
// Description : Constants shared by both ends of the strobed serial link:
//               receiver/transmitter FSM state encoding and the
//               extension-type select values.
// Revision    : 1.0 - initial release
// ============================================================================
package ser_pkg;

  // FSM state encoding, shared by the receive and transmit sides
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Values of ext_type
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

endpackage : ser_pkg
`default_nettype wire

// File: rtl/ser_ext.sv
`default_nettype none
// ============================================================================
// Module      : ser_ext
// Description : Combinational extender. Widens a W-bit frame to OW bits,
//               either zero-extended or sign-extended (two's complement).
//               When OW == W the frame passes through unchanged.
// Ports       : i_f        - W-bit frame
//               i_ext_type - EXT_ZERO / EXT_SIGN
//               o_word     - OW-bit extended word
// Revision    : 1.0 - initial release
// ============================================================================
module ser_ext
  import ser_pkg::*;
#(
  parameter int W  = 4,
  parameter int OW = 8
) (
  input  logic [W-1:0]  i_f,
  input  logic          i_ext_type,
  output logic [OW-1:0] o_word
);

  generate
    if (OW > W) begin : g_extend
      logic w_fill;
      // Fill bit is the frame MSB for sign extension, otherwise zero
      assign w_fill = (i_ext_type == EXT_SIGN) ? i_f[W-1] : 1'b0;
      assign o_word = {{(OW - W){w_fill}}, i_f};
    end else begin : g_passthru
      // No room to extend, so the extension type has no effect
      logic w_unused_ext;
      assign w_unused_ext = i_ext_type;
      assign o_word       = i_f;
    end
  endgenerate

endmodule : ser_ext
`default_nettype wire

// File: rtl/ser_rx.sv
`default_nettype none
// ============================================================================
// Module      : ser_rx
// Description : Serial-to-parallel receiver. Collects a W-bit frame sent LSB
//               first (one bit per i_sin_en strobe, shifting right with the
//               new bit at the MSB), then presents it zero- or sign-extended
//               to OW bits through a valid/read handshake with a sticky
//               overrun flag.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-high reset
//               i_start      - frame start / restart pulse
//               i_sin        - serial data bit
//               i_sin_en     - bit strobe
//               i_ext_type   - EXT_ZERO / EXT_SIGN, sampled on completion
//               i_rd         - consumer acknowledge, clears valid and ovf
//               o_data_out   - last completed word, extended
//               o_valid      - o_data_out holds an unread word
//               o_busy       - frame in progress
//               o_ovf        - sticky overrun flag
// Revision    : 1.0 - initial release
// ============================================================================
module ser_rx
  import ser_pkg::*;
#(
  parameter int W  = 4,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_sin,
  input  logic          i_sin_en,
  input  logic          i_ext_type,
  input  logic          i_rd,
  output logic [OW-1:0] o_data_out,
  output logic          o_valid,
  output logic          o_busy,
  output logic          o_ovf
);

  localparam int            CW     = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(W - 1);

  ser_state_t    r_state;
  ser_state_t    w_state_nxt;
  logic [W-1:0]  r_shreg;
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_data_out;
  logic          r_valid;
  logic          r_ovf;

  logic          w_in_shift;
  logic          w_shift;
  logic          w_complete;
  logic [W-1:0]  w_frame;
  logic [OW-1:0] w_ext_word;

  // The oldest bit drops out of the frame as the last bit enters, so
  // r_shreg[0] is never consumed.
  logic          w_unused_lsb;
  assign w_unused_lsb = r_shreg[0];

  assign w_in_shift = (r_state == S_SHIFT);
  // A start pulse always takes priority over a strobe, including on what
  // would otherwise have been the completing edge.
  assign w_shift    = w_in_shift && i_sin_en && !i_start;
  assign w_complete = w_shift && (r_cnt == c_LAST);
  assign w_frame    = {i_sin, r_shreg[W-1:1]};

  ser_ext #(
    .W  (W),
    .OW (OW)
  ) u_ext (
    .i_f        (w_frame),
    .i_ext_type (i_ext_type),
    .o_word     (w_ext_word)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_start) begin
          w_state_nxt = S_SHIFT;
        end else if (w_complete) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift register and bit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_shreg <= w_frame;
      // Explicit wrap keeps non-power-of-two frame lengths correct
      r_cnt   <= w_complete ? '0 : r_cnt + CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output word and handshake flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_complete) begin
      r_data_out <= w_ext_word;
      r_valid    <= 1'b1;
      // Overwriting an unread word is an overrun, unless the consumer reads
      // it on this very edge, in which case the flag is cleared instead.
      r_ovf      <= i_rd ? 1'b0 : (r_ovf | r_valid);
    end else if (i_rd) begin
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end
  end

  assign o_data_out = r_data_out;
  assign o_valid    = r_valid;
  assign o_busy     = w_in_shift;
  assign o_ovf      = r_ovf;

endmodule : ser_rx
`default_nettype wire

// File: tb/tb_ser_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ser_rx
// Description : Self-checking bench for ser_rx (W=4, OW=8). Expected words
//               are queued when a frame's last bit is driven and compared
//               when the receiver signals completion (busy falling).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ser_rx;

  localparam int W  = 4;
  localparam int OW = 8;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          ovf;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          i_sin;
  logic          i_sin_en;
  logic          i_ext_type;
  logic          i_rd;
  logic [OW-1:0] o_data_out;
  logic          o_valid;
  logic          o_busy;
  logic          o_ovf;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  // Reference handshake state
  logic m_valid = 1'b0;
  logic m_ovf   = 1'b0;

  ser_rx #(
    .W  (W),
    .OW (OW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_sin      (i_sin),
    .i_sin_en   (i_sin_en),
    .i_ext_type (i_ext_type),
    .i_rd       (i_rd),
    .o_data_out (o_data_out),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_ovf      (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each falling edge of busy outside reset is a completed frame
  logic mon_prev_busy = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      mon_prev_busy = 1'b0;
    end else begin
      if (mon_prev_busy && !o_busy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("data_out", 32'(o_data_out), 32'(e.data));
          chk("valid",    32'(o_valid),    32'd1);
          chk("ovf",      32'(o_ovf),      32'(e.ovf));
        end
      end
      mon_prev_busy = o_busy;
    end
  end

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
  endtask

  // Drives the W bits of a frame; the last bit carries ext/rd and queues
  // the expected word.
  task automatic send_bits(input logic [W-1:0] bits, input logic ext, input logic rd_last);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      i_sin    = bits[i];
      i_sin_en = 1'b1;
      if (i == W - 1) begin
        i_ext_type = ext;
        i_rd       = rd_last;
        e.data     = ext ? {{(OW - W){bits[W-1]}}, bits} : {{(OW - W){1'b0}}, bits};
        e.ovf      = rd_last ? 1'b0 : (m_valid | m_ovf);
        sb_q.push_back(e);
        m_valid    = 1'b1;
        m_ovf      = e.ovf;
      end
      tick();
      i_sin_en = 1'b0;
      i_rd     = 1'b0;
    end
    chk("busy_after_frame", 32'(o_busy), 32'd0);
  endtask

  task automatic send_frame(input logic [W-1:0] bits, input logic ext, input logic rd_last);
    start_pulse();
    send_bits(bits, ext, rd_last);
  endtask

  task automatic do_read();
    i_rd = 1'b1;
    tick();
    i_rd    = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    chk("valid_after_rd", 32'(o_valid), 32'd0);
    chk("ovf_after_rd",   32'(o_ovf),   32'd0);
  endtask

  initial begin
    // Reset with random inputs
    rst        = 1'b1;
    i_start    = 1'($urandom);
    i_sin      = 1'($urandom);
    i_sin_en   = 1'($urandom);
    i_ext_type = 1'($urandom);
    i_rd       = 1'($urandom);
    #25;
    chk("rst_data",  32'(o_data_out), 32'd0);
    chk("rst_valid", 32'(o_valid),    32'd0);
    chk("rst_busy",  32'(o_busy),     32'd0);
    chk("rst_ovf",   32'(o_ovf),      32'd0);
    i_start = 1'b0; i_sin = 1'b0; i_sin_en = 1'b0; i_ext_type = 1'b0; i_rd = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Zero-extend then read
    send_frame(4'b1010, 1'b0, 1'b0);
    do_read();

    // Sign-extend, negative and positive frames
    send_frame(4'b1010, 1'b1, 1'b0);
    do_read();
    send_frame(4'b0011, 1'b1, 1'b0);
    do_read();

    // Gaps, then restart: the aborted frame must produce nothing
    start_pulse();
    i_sin_en = 1'b1; i_sin = 1'b1; tick();
    i_sin = 1'b1; tick();
    i_sin_en = 1'b0;
    repeat (3) tick();
    chk("gap_busy",  32'(o_busy),  32'd1);
    chk("gap_valid", 32'(o_valid), 32'd0);
    send_frame(4'b1000, 1'b0, 1'b0);
    do_read();

    // Start on the would-be completing edge wins; frame restarts
    start_pulse();
    i_sin_en = 1'b1; i_sin = 1'b1;
    repeat (3) tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0; i_sin_en = 1'b0;
    chk("abort_busy",  32'(o_busy),  32'd1);
    chk("abort_valid", 32'(o_valid), 32'd0);
    send_bits(4'b0101, 1'b0, 1'b0);
    do_read();

    // Overrun, then read clears it
    send_frame(4'b1010, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0);
    chk("ovr_data", 32'(o_data_out), 32'h06);
    chk("ovr_ovf",  32'(o_ovf),      32'd1);
    do_read();

    // Completion with rd on the same edge
    send_frame(4'b1100, 1'b1, 1'b0);
    send_frame(4'b0111, 1'b1, 1'b1);
    chk("same_edge_valid", 32'(o_valid), 32'd1);
    chk("same_edge_ovf",   32'(o_ovf),   32'd0);

    // Back-to-back: start on the cycle right after completion
    send_frame(4'b1001, 1'b0, 1'b1);

    // Reset mid-frame with a word held
    start_pulse();
    i_sin_en = 1'b1; i_sin = 1'b1; tick();
    tick();
    i_sin_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_data",  32'(o_data_out), 32'd0);
    chk("midrst_valid", 32'(o_valid),    32'd0);
    chk("midrst_busy",  32'(o_busy),     32'd0);
    chk("midrst_ovf",   32'(o_ovf),      32'd0);
    rst     = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    tick();
    send_frame(4'b1101, 1'b1, 1'b0);
    do_read();

    repeat (2) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ser_rx
`default_nettype wire
